// File: rtl/core_pkg.sv
// Shared core types: fetch FIFO entry, fetch FSM states and the default boot address.
package core_pkg;

    localparam logic [29:0] CORE_RESET_ADDR = 30'h0000_0000;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RESET,
        FS_RUN
    } fetch_state_e;

endpackage

// File: rtl/core_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush beats push and pop.
module core_fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned  DEPTH     = 2,
    parameter fetch_entry_t RESET_VAL = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push & ~i_flush;
    assign do_pop  = i_pop & ~i_flush & (count_q != '0);

    // Storage is reset too so the head reads a defined value while empty.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VAL;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited memory
// requests, buffers in-order responses and squashes stale words on redirect.
module core_fetch
    import core_pkg::*;
#(
    parameter logic [29:0] RESET_ADDR = CORE_RESET_ADDR,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pc_src,
    input  logic [29:0] i_pc_target,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [29:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [29:0] o_pc
);
    localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_W = DEPTH[CNT_W:0];
    localparam fetch_entry_t      FIFO_RESET = '{pc: RESET_ADDR, instr: 32'h0};

    fetch_state_e     state_q;
    logic [29:0]      pc_q, pc_d;
    logic [29:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] fifo_count;
    logic             run, redirect, credit, fire, rsp, push, pop;
    fetch_entry_t     head, push_entry;

    assign run      = (state_q == FS_RUN);
    assign redirect = run & i_pc_src;
    assign credit   = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W;
    assign fire     = o_imem_req & i_imem_ack;
    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp      = i_imem_rvalid & (outstanding_q != '0);
    assign push     = rsp & ~redirect & (drop_cnt_q == '0);
    assign pop      = o_instr_valid & ~i_stall;

    assign o_imem_req    = run & ~i_pc_src & credit;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = (fifo_count != '0) & ~i_pc_src;
    assign o_instr       = head.instr;
    assign o_pc          = head.pc;
    assign push_entry    = '{pc: resp_pc_q, instr: i_imem_rdata};

    // outstanding counts every in-flight word, stale ones included, so on a
    // redirect all of it (minus the word retiring now) becomes drop budget.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(rsp);
        if (redirect) begin
            pc_d       = i_pc_target;
            resp_pc_d  = i_pc_target;
            drop_cnt_d = outstanding_q - CNT_W'(rsp);
        end else begin
            if (fire) pc_d = pc_q + 30'd1;
            if (push) resp_pc_d = resp_pc_q + 30'd1;
            if (rsp && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= FS_RESET;
            pc_q          <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= FS_RUN;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    core_fetch_fifo #(
        .DEPTH     (DEPTH),
        .RESET_VAL (FIFO_RESET)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_entry   (push_entry),
        .i_pop     (pop),
        .i_flush   (redirect),
        .o_count   (fifo_count),
        .o_head    (head)
    );

    a_rvalid_expected: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_imem_rvalid |-> (outstanding_q != '0));

endmodule
